// File: rtl/opll_write_sequencer.sv
// opll_write_sequencer
// Queues host register writes in a small FIFO and replays each one onto a
// shared YM2413-style (OPLL) bus. Each write is an address strobe followed by
// a data strobe, and each strobe is followed by the bus recovery time the chip
// needs.
//
// state        | meaning
// -------------+-------------------------------------------------------
// S_IDLE       | waiting; pops the FIFO head into the holding register
// S_ADDR_PULSE | WR low, A0=0, D=address, selected chip's CS low
// S_ADDR_WAIT  | WR/CS high, address recovery time
// S_DATA_PULSE | WR low, A0=1, D=data, selected chip's CS low
// S_DATA_WAIT  | WR/CS high, data recovery time
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   i_wr_valid/o_wr_ready/i_wr_chip/i_wr_addr/i_wr_data   host write port
//   o_cs_n, o_wr_n, o_a0, o_d                            OPLL bus (registered)
//   o_busy, o_level, o_err                               status
module opll_write_sequencer #(
  parameter int DEPTH     = 4,
  parameter int CHIPS     = 2,
  parameter int PULSE_W   = 2,
  parameter int ADDR_WAIT = 12,
  parameter int DATA_WAIT = 84,
  localparam int CW = (CHIPS > 1) ? $clog2(CHIPS) : 1,
  localparam int LW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_wr_valid,
  output logic             o_wr_ready,
  input  logic [CW-1:0]    i_wr_chip,
  input  logic [7:0]       i_wr_addr,
  input  logic [7:0]       i_wr_data,
  output logic [CHIPS-1:0] o_cs_n,
  output logic             o_wr_n,
  output logic             o_a0,
  output logic [7:0]       o_d,
  output logic             o_busy,
  output logic [LW-1:0]    o_level,
  output logic             o_err
);

  localparam int PW    = $clog2(DEPTH);
  localparam int EW    = CW + 16;
  localparam int MAX_A = (PULSE_W > ADDR_WAIT) ? PULSE_W : ADDR_WAIT;
  localparam int MAX_L = (MAX_A > DATA_WAIT) ? MAX_A : DATA_WAIT;
  localparam int CNTW  = (MAX_L > 1) ? $clog2(MAX_L) : 1;

  // Down-counter reload values: a state lasting N cycles loads N-1 and
  // leaves when the count reaches zero.
  localparam logic [CNTW-1:0] LD_PULSE = CNTW'(PULSE_W - 1);
  localparam logic [CNTW-1:0] LD_AWAIT = CNTW'(ADDR_WAIT - 1);
  localparam logic [CNTW-1:0] LD_DWAIT = CNTW'(DATA_WAIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR_PULSE,
    S_ADDR_WAIT,
    S_DATA_PULSE,
    S_DATA_WAIT
  } state_t;

  state_t            state, state_nxt;
  logic [CNTW-1:0]   cnt, cnt_nxt;
  logic [EW-1:0]     mem [DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [LW-1:0]     level;
  logic              push, pop;
  logic [CW-1:0]     head_chip;
  logic [CW-1:0]     hold_chip;
  logic [7:0]        hold_addr, hold_data;
  logic [CHIPS-1:0]  cs_sel;
  logic              busy_r;

  // Ready depends only on the stored level, so a full FIFO never accepts,
  // even in a cycle where the sequencer is popping.
  assign o_wr_ready = (level < LW'(DEPTH));
  assign push       = i_wr_valid & o_wr_ready & ~rst;
  assign head_chip  = mem[rd_ptr][EW-1:16];
  assign o_level    = level;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {i_wr_chip, i_wr_addr, i_wr_data};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (pop) begin
      {hold_chip, hold_addr, hold_data} <= mem[rd_ptr];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pop       = 1'b0;
    case (state)
      S_IDLE: begin
        if (level != '0) begin
          pop       = 1'b1;
          state_nxt = S_ADDR_PULSE;
          cnt_nxt   = LD_PULSE;
        end
      end
      S_ADDR_PULSE: begin
        if (cnt == '0) begin
          state_nxt = S_ADDR_WAIT;
          cnt_nxt   = LD_AWAIT;
        end else begin
          cnt_nxt = cnt - CNTW'(1);
        end
      end
      S_ADDR_WAIT: begin
        if (cnt == '0) begin
          state_nxt = S_DATA_PULSE;
          cnt_nxt   = LD_PULSE;
        end else begin
          cnt_nxt = cnt - CNTW'(1);
        end
      end
      S_DATA_PULSE: begin
        if (cnt == '0) begin
          state_nxt = S_DATA_WAIT;
          cnt_nxt   = LD_DWAIT;
        end else begin
          cnt_nxt = cnt - CNTW'(1);
        end
      end
      S_DATA_WAIT: begin
        if (cnt == '0) begin
          state_nxt = S_IDLE;
        end else begin
          cnt_nxt = cnt - CNTW'(1);
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // An out-of-range chip index matches no bit, so every select stays high
  // while the strobes still run their normal timing.
  always_comb begin
    cs_sel = '1;
    for (int i = 0; i < CHIPS; i++) begin
      if (int'(hold_chip) == i) cs_sel[i] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_err <= 1'b0;
    end else if (pop && (int'(head_chip) >= CHIPS)) begin
      o_err <= 1'b1;
    end
  end

  // Bus pins are registered from the current state, so they trail the state
  // register by one cycle. A0 and D are left alone outside the pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_wr_n <= 1'b1;
      o_cs_n <= '1;
      o_a0   <= 1'b0;
      o_d    <= '0;
      busy_r <= 1'b0;
    end else begin
      busy_r <= (state != S_IDLE);
      case (state)
        S_ADDR_PULSE: begin
          o_wr_n <= 1'b0;
          o_cs_n <= cs_sel;
          o_a0   <= 1'b0;
          o_d    <= hold_addr;
        end
        S_DATA_PULSE: begin
          o_wr_n <= 1'b0;
          o_cs_n <= cs_sel;
          o_a0   <= 1'b1;
          o_d    <= hold_data;
        end
        default: begin
          o_wr_n <= 1'b1;
          o_cs_n <= '1;
        end
      endcase
    end
  end

  // busy_r covers the final registered bus cycle after the FSM is back in IDLE.
  assign o_busy = (state != S_IDLE) | busy_r | (level != '0);

endmodule
